// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// drives every datapath select and enable, counts retirements and halts on faults.
module rv32i_multicycle_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MEM_TO_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_inst,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int TO_W = (MEM_TO_MAX > 0) ? $clog2(MEM_TO_MAX + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO_MAX - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IARITH, C_LOAD, C_STORE, C_BRANCH,
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
    } class_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
    } imm_e;

    state_e          state;
    state_e          state_next;
    class_e          cls;
    class_e          cls_dec;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting;
    logic            timeout;
    logic            mem_err_q;

    function automatic class_e classify(input logic [6:0] op);
        case (op)
            OP_R:      return C_R;
            OP_IARITH: return C_IARITH;
            OP_LOAD:   return C_LOAD;
            OP_STORE:  return C_STORE;
            OP_BRANCH: return C_BRANCH;
            OP_LUI:    return C_LUI;
            OP_AUIPC:  return C_AUIPC;
            OP_JAL:    return C_JAL;
            OP_JALR:   return C_JALR;
            default:   return C_ILLEGAL;
        endcase
    endfunction

    function automatic imm_e imm_of(input class_e c);
        case (c)
            C_STORE:        return IMM_S;
            C_BRANCH:       return IMM_B;
            C_LUI, C_AUIPC: return IMM_U;
            C_JAL:          return IMM_J;
            default:        return IMM_I;
        endcase
    endfunction

    assign cls_dec = classify(opcode);

    // Only FETCH and MEM wait on the memory port; a stall there counts toward the timeout.
    assign waiting = (MEM_TO_MAX > 0) && (state == S_FETCH || state == S_MEM) && !mem_ready;
    assign timeout = waiting && (wait_cnt == TO_LAST);

    assign halted  = (state == S_HALT);
    assign mem_err = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            cls       <= C_R;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            instret   <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge values of the others.
            state <= state_next;
            if (state == S_DECODE)
                cls <= cls_dec;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + TO_W'(1);
            if (timeout)
                mem_err_q <= 1'b1;
            if (pc_we)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no branch below can infer a latch.
        state_next  = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_inst = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        imm_sel     = IMM_I;
        alu_a_sel   = 2'd0;
        alu_b_sel   = 1'b0;
        alu_op      = 2'd0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;

        // Gating with rst_n keeps the fetch request and enables quiet while reset is held.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    mem_is_inst = 1'b1;
                    if (timeout) begin
                        state_next = S_HALT;
                    end else if (mem_ready) begin
                        ir_we      = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    imm_sel    = imm_of(cls_dec);
                    state_next = (cls_dec == C_ILLEGAL) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    imm_sel    = imm_of(cls);
                    state_next = S_WB;
                    case (cls)
                        C_R: begin
                            alu_op = 2'd1;
                        end
                        C_IARITH: begin
                            alu_b_sel = 1'b1;
                            alu_op    = 2'd1;
                        end
                        C_LOAD, C_STORE: begin
                            alu_b_sel  = 1'b1;
                            state_next = S_MEM;
                        end
                        C_LUI: begin
                            alu_a_sel = 2'd2;
                            alu_b_sel = 1'b1;
                        end
                        C_AUIPC: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 1'b1;
                        end
                        C_BRANCH: begin
                            alu_op     = 2'd2;
                            pc_we      = 1'b1;
                            pc_sel     = br_taken ? 2'd1 : 2'd0;
                            state_next = S_FETCH;
                        end
                        default: begin
                            alu_b_sel = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == C_STORE);
                    imm_sel = imm_of(cls);
                    if (timeout) begin
                        state_next = S_HALT;
                    end else if (mem_ready) begin
                        if (cls == C_STORE) begin
                            pc_we      = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            state_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    imm_sel    = imm_of(cls);
                    state_next = S_FETCH;
                    case (cls)
                        C_LOAD:  wb_sel = 2'd1;
                        C_JAL:   begin wb_sel = 2'd2; pc_sel = 2'd1; end
                        C_JALR:  begin wb_sel = 2'd2; pc_sel = 2'd2; end
                        default: wb_sel = 2'd0;
                    endcase
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: directed vector table, corner-case
// sequences (waits, timeout, illegal opcode, async reset) and randomized instruction streams.
module tb_rv32i_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int TO    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       opcode = '0;
    logic             br_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, mem_is_inst, ir_we, pc_we;
    logic [1:0]       pc_sel;
    logic [2:0]       imm_sel;
    logic [1:0]       alu_a_sel;
    logic             alu_b_sel;
    logic [1:0]       alu_op;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             halted, mem_err;
    logic [CNT_W-1:0] instret;

    rv32i_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TO_MAX(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_is_inst(mem_is_inst), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted),
        .mem_err(mem_err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             mem_is_inst;
        logic             ir_we;
        logic             pc_we;
        logic [1:0]       pc_sel;
        logic [2:0]       imm_sel;
        logic [1:0]       alu_a_sel;
        logic             alu_b_sel;
        logic [1:0]       alu_op;
        logic             rf_we;
        logic [1:0]       wb_sel;
        logic             halted;
        logic             mem_err;
        logic [CNT_W-1:0] instret;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic       tkn;
        outs_t      exp;
    } vec_t;

    outs_t got;
    assign got = {mem_req, mem_we, mem_is_inst, ir_we, pc_we, pc_sel, imm_sel,
                  alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, halted, mem_err, instret};

    vec_t       tbl[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         retired = 0;
    logic       err_seen = 1'b0;
    logic       halt_seen = 1'b0;
    logic [6:0] legal_ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

    task automatic check(input string name, input outs_t g, input outs_t e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, g, e);
        end
    endtask

    // Reference rules, written per instruction kind rather than per controller state.
    function automatic bit legal(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h37, 7'h17: return 3'd3;
            7'h6F:        return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic outs_t idle();
        outs_t e = '0;
        e.instret = CNT_W'(retired);
        return e;
    endfunction

    function automatic outs_t exp_fetch(input logic rdy);
        outs_t e = idle();
        e.mem_req = 1'b1; e.mem_is_inst = 1'b1; e.ir_we = rdy;
        return e;
    endfunction

    function automatic outs_t exp_decode(input logic [6:0] op);
        outs_t e = idle();
        e.imm_sel = imm_of(op);
        return e;
    endfunction

    function automatic outs_t exp_exec(input logic [6:0] op, input logic tkn);
        outs_t e = idle();
        e.imm_sel = imm_of(op);
        case (op)
            7'h33: e.alu_op = 2'd1;
            7'h13: begin e.alu_b_sel = 1'b1; e.alu_op = 2'd1; end
            7'h37: begin e.alu_a_sel = 2'd2; e.alu_b_sel = 1'b1; end
            7'h17: begin e.alu_a_sel = 2'd1; e.alu_b_sel = 1'b1; end
            7'h63: begin e.alu_op = 2'd2; e.pc_we = 1'b1; e.pc_sel = tkn ? 2'd1 : 2'd0; end
            default: e.alu_b_sel = 1'b1;
        endcase
        return e;
    endfunction

    function automatic outs_t exp_mem(input logic [6:0] op, input logic rdy);
        outs_t e = idle();
        e.mem_req = 1'b1;
        e.mem_we  = (op == 7'h23);
        e.imm_sel = imm_of(op);
        e.pc_we   = (op == 7'h23) && rdy;
        return e;
    endfunction

    function automatic outs_t exp_wb(input logic [6:0] op);
        outs_t e = idle();
        e.rf_we = 1'b1; e.pc_we = 1'b1; e.imm_sel = imm_of(op);
        e.wb_sel = (op == 7'h03) ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : 2'd0;
        e.pc_sel = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
        return e;
    endfunction

    function automatic outs_t exp_halt();
        outs_t e = idle();
        e.halted = 1'b1; e.mem_err = err_seen;
        return e;
    endfunction

    function automatic void retire();
        retired = (retired + 1) % (1 << CNT_W);
    endfunction

    // Called on a falling edge; drives one cycle, samples mid-cycle, returns on the next falling edge.
    task automatic tick(input string name, input logic [6:0] op, input logic rdy,
                        input logic tkn, input outs_t e);
        opcode = op; mem_ready = rdy; br_taken = tkn;
        #1;
        check(name, got, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        retired = 0; err_seen = 1'b0; halt_seen = 1'b0;
        #1;
        check("reset_assert", got, '0);
        mem_ready = 1'b1;
        #1;
        check("reset_ready_ignored", got, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic tkn);
        for (int i = 0; i <= fw; i++) begin
            if (i == TO) begin
                err_seen = 1'b1; halt_seen = 1'b1;
                tick("timeout_fetch", 7'($urandom), 1'($urandom), 1'($urandom), exp_halt());
                return;
            end
            tick("fetch", 7'($urandom), (i == fw), 1'($urandom), exp_fetch(i == fw));
        end
        tick("decode", op, 1'($urandom), 1'($urandom), exp_decode(op));
        if (!legal(op)) begin
            halt_seen = 1'b1;
            tick("halt_illegal", op, 1'($urandom), 1'($urandom), exp_halt());
            return;
        end
        tick("exec", op, 1'($urandom), tkn, exp_exec(op, tkn));
        if (op == 7'h63) begin
            retire();
            return;
        end
        if (op == 7'h03 || op == 7'h23) begin
            for (int j = 0; j <= mw; j++) begin
                if (j == TO) begin
                    err_seen = 1'b1; halt_seen = 1'b1;
                    tick("timeout_mem", op, 1'($urandom), 1'($urandom), exp_halt());
                    return;
                end
                tick("mem", op, (j == mw), 1'($urandom), exp_mem(op, j == mw));
            end
            if (op == 7'h23) begin
                retire();
                return;
            end
        end
        tick("wb", op, 1'($urandom), 1'($urandom), exp_wb(op));
        retire();
    endtask

    task automatic add(input logic [6:0] op, input logic rdy, input logic tkn, input outs_t e);
        tbl.push_back('{op, rdy, tkn, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active, expected summary line");
        $fatal(1);
    end

    initial begin
        outs_t e;

        // ADDI x1,x0,5 (instret 0)
        e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.ir_we = 1;          add(7'h13, 1, 0, e);
        e = '0;                                                         add(7'h13, 1, 0, e);
        e = '0; e.alu_b_sel = 1; e.alu_op = 2'd1;                       add(7'h13, 1, 0, e);
        e = '0; e.rf_we = 1; e.pc_we = 1;                               add(7'h13, 1, 0, e);
        // BEQ taken (instret 1)
        e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.ir_we = 1; e.instret = 4'd1; add(7'h63, 1, 1, e);
        e = '0; e.imm_sel = 3'd2; e.instret = 4'd1;                     add(7'h63, 1, 1, e);
        e = '0; e.imm_sel = 3'd2; e.alu_op = 2'd2; e.pc_we = 1; e.pc_sel = 2'd1; e.instret = 4'd1;
        add(7'h63, 1, 1, e);
        // BEQ not taken (instret 2)
        e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.ir_we = 1; e.instret = 4'd2; add(7'h63, 1, 0, e);
        e = '0; e.imm_sel = 3'd2; e.instret = 4'd2;                     add(7'h63, 1, 0, e);
        e = '0; e.imm_sel = 3'd2; e.alu_op = 2'd2; e.pc_we = 1; e.instret = 4'd2;
        add(7'h63, 1, 0, e);
        // JALR (instret 3)
        e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.ir_we = 1; e.instret = 4'd3; add(7'h67, 1, 0, e);
        e = '0; e.instret = 4'd3;                                       add(7'h67, 1, 0, e);
        e = '0; e.alu_b_sel = 1; e.instret = 4'd3;                      add(7'h67, 1, 0, e);
        e = '0; e.rf_we = 1; e.pc_we = 1; e.wb_sel = 2'd2; e.pc_sel = 2'd2; e.instret = 4'd3;
        add(7'h67, 1, 0, e);
        // LUI (instret 4)
        e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.ir_we = 1; e.instret = 4'd4; add(7'h37, 1, 0, e);
        e = '0; e.imm_sel = 3'd3; e.instret = 4'd4;                     add(7'h37, 1, 0, e);
        e = '0; e.imm_sel = 3'd3; e.alu_a_sel = 2'd2; e.alu_b_sel = 1; e.instret = 4'd4;
        add(7'h37, 1, 0, e);
        e = '0; e.imm_sel = 3'd3; e.rf_we = 1; e.pc_we = 1; e.instret = 4'd4;
        add(7'h37, 1, 0, e);
        // First fetch after LUI retired (instret 5)
        e = '0; e.mem_req = 1; e.mem_is_inst = 1; e.instret = 4'd5;     add(7'h13, 0, 0, e);

        @(negedge clk);
        do_reset();
        for (int k = 0; k < tbl.size(); k++)
            tick($sformatf("vec%0d", k), tbl[k].op, tbl[k].rdy, tbl[k].tkn, tbl[k].exp);
        // Last vector left one fetch wait counted; reset to restart from a clean handshake.
        do_reset();

        // LW with three MEM stall cycles, then a fetch stalled just under the limit.
        run_instr(7'h03, 0, 3, 1'b0);
        run_instr(7'h33, 3, 0, 1'b0);
        run_instr(7'h23, 2, 3, 1'b0);

        // Illegal opcode: halt, stay silent, reset clears instret.
        run_instr(7'h7F, 0, 0, 1'b0);
        for (int k = 0; k < 20; k++)
            tick("halt_hold", 7'($urandom), 1'($urandom), 1'($urandom), exp_halt());
        do_reset();
        run_instr(7'h6F, 0, 0, 1'b0);

        // Fetch timeout, then MEM timeout.
        run_instr(7'h13, 4, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            tick("halt_after_to", 7'($urandom), 1'($urandom), 1'($urandom), exp_halt());
        do_reset();
        run_instr(7'h03, 0, 4, 1'b0);
        tick("halt_after_mem_to", 7'h03, 1'b1, 1'b0, exp_halt());
        do_reset();

        // Async reset in the middle of a stalled load.
        tick("mid_fetch", 7'h00, 1'b1, 1'b0, exp_fetch(1'b1));
        tick("mid_decode", 7'h03, 1'b0, 1'b0, exp_decode(7'h03));
        tick("mid_exec", 7'h03, 1'b0, 1'b0, exp_exec(7'h03, 1'b0));
        tick("mid_mem_wait", 7'h03, 1'b0, 1'b0, exp_mem(7'h03, 1'b0));
        opcode = 7'h03; mem_ready = 1'b0;
        #1;
        check("mid_mem_before_reset", got, exp_mem(7'h03, 1'b0));
        #1;
        do_reset();
        run_instr(7'h17, 3, 0, 1'b0);

        // Randomized streams, including instret wrap, occasional illegal opcodes and timeouts.
        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            int fw, mw;
            if ($urandom_range(0, 19) == 0) begin
                do op = 7'($urandom); while (legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            fw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
            run_instr(op, fw, mw, 1'($urandom));
            if (halt_seen) begin
                for (int k = 0; k < 3; k++)
                    tick("rand_halt", 7'($urandom), 1'($urandom), 1'($urandom), exp_halt());
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
